if_stage: RTL and testbench

//  Instruction-fetch stage of the pipelined MIPS core: holds the PC, drives the instruction memory address and

---
 rtl/if_stage.sv | 118 +++++++++++
 tb/tb_if_stage.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the fetch PC, addresses instruction memory and fills the IF/ID register.
// Optional perf counters (fetch_cnt, stall_cnt) are compiled in when IF_PERF_CNT_EN is defined.
module if_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        is_branch_d,
    input  logic        exc_req,
    input  logic        eret,
    input  logic [31:0] epc,
    output logic [31:0] im_addr,
    input  logic [31:0] im_ins,
    input  logic [4:0]  im_ex,
    output logic [31:0] ir_d,
    output logic [31:0] pc_d,
    output logic [4:0]  ex_d,
    output logic        bd_d,
    output logic        valid_d
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] stall_cnt
`endif
);

    logic [31:0] pc_f_r;
    logic [31:0] pc_f_next_s;
    logic [31:0] bubble_pc_s;
    logic        load_s;
    logic        bubble_s;
    logic        stall_hold_s;

    assign im_addr = pc_f_r;

    // Next-PC selection and IF/ID action; exc_req and eret both outrank stall
    always_comb begin
        pc_f_next_s  = pc_f_r;
        bubble_pc_s  = pc_f_r;
        load_s       = 1'b0;
        bubble_s     = 1'b0;
        stall_hold_s = 1'b0;
        if (exc_req) begin
            pc_f_next_s = EXC_VECTOR;
            bubble_pc_s = EXC_VECTOR;
            bubble_s    = 1'b1;
        end else if (eret) begin
            pc_f_next_s = epc;
            bubble_pc_s = epc;
            bubble_s    = 1'b1;
        end else if (stall) begin
            stall_hold_s = 1'b1;
        end else if (redirect_valid) begin
            // The word fetched this cycle is the delay slot, so it still enters IF/ID
            pc_f_next_s = redirect_pc;
            load_s      = 1'b1;
        end else begin
            pc_f_next_s = pc_f_r + 32'd4;
            load_s      = 1'b1;
        end
    end

    // Fetch PC register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_f_r <= RESET_PC;
        end else begin
            pc_f_r <= pc_f_next_s;
        end
    end

    // IF/ID pipeline register: bubble, load, or hold
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ir_d    <= 32'd0;
            pc_d    <= 32'd0;
            ex_d    <= 5'd0;
            bd_d    <= 1'b0;
            valid_d <= 1'b0;
        end else if (bubble_s) begin
            ir_d    <= 32'd0;
            pc_d    <= bubble_pc_s;
            ex_d    <= 5'd0;
            bd_d    <= 1'b0;
            valid_d <= 1'b0;
        end else if (load_s) begin
            ir_d    <= im_ins;
            pc_d    <= pc_f_r;
            ex_d    <= im_ex;
            bd_d    <= is_branch_d;
            valid_d <= 1'b1;
        end else begin
            ir_d    <= ir_d;
            pc_d    <= pc_d;
            ex_d    <= ex_d;
            bd_d    <= bd_d;
            valid_d <= valid_d;
        end
    end

`ifdef IF_PERF_CNT_EN
    // Free-running fetch and stall counters, wrapping modulo 2^32
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_cnt <= 32'd0;
            stall_cnt <= 32'd0;
        end else begin
            fetch_cnt <= load_s       ? fetch_cnt + 32'd1 : fetch_cnt;
            stall_cnt <= stall_hold_s ? stall_cnt + 32'd1 : stall_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a combinational instruction-memory model.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        is_branch_d;
    logic        exc_req;
    logic        eret;
    logic [31:0] epc;
    logic [31:0] im_addr;
    logic [31:0] im_ins;
    logic [4:0]  im_ex;
    logic [31:0] ir_d;
    logic [31:0] pc_d;
    logic [4:0]  ex_d;
    logic        bd_d;
    logic        valid_d;
`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    if_stage dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .is_branch_d    (is_branch_d),
        .exc_req        (exc_req),
        .eret           (eret),
        .epc            (epc),
        .im_addr        (im_addr),
        .im_ins         (im_ins),
        .im_ex          (im_ex),
        .ir_d           (ir_d),
        .pc_d           (pc_d),
        .ex_d           (ex_d),
        .bd_d           (bd_d),
        .valid_d        (valid_d)
`ifdef IF_PERF_CNT_EN
        ,
        .fetch_cnt      (fetch_cnt),
        .stall_cnt      (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a[1:0] != 2'd0) return 32'd0;
        return a ^ 32'hA5A5_0000;
    endfunction

    // Memory model: misaligned fetches return AdEL with a zero word
    always_comb begin
        im_ins = mem_word(im_addr);
        im_ex  = (im_addr[1:0] != 2'd0) ? 5'd4 : 5'd0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
        is_branch_d = 1'b0; exc_req = 1'b0; eret = 1'b0; epc = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst_pc", im_addr, 32'h3000);
        chk("rst_valid", {31'd0, valid_d}, 32'd0);
        chk("rst_ir", ir_d, 32'd0);
        chk("rst_pcd", pc_d, 32'd0);
        chk("rst_bd_ex", {26'd0, bd_d, ex_d}, 32'd0);
        reset_n = 1'b1;
        repeat (2) tick();
        chk("run_valid", {31'd0, valid_d}, 32'd1);

        // mid-run asynchronous reset
        #1 reset_n = 1'b0;
        #1;
        chk("mrst_pc", im_addr, 32'h3000);
        chk("mrst_valid", {31'd0, valid_d}, 32'd0);
        chk("mrst_ir", ir_d, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) tick();
        chk("seq_pc", im_addr, 32'h300C);
        chk("seq_pcd", pc_d, 32'h3008);
        chk("seq_valid", {31'd0, valid_d}, 32'd1);
        chk("seq_ir", ir_d, 32'hA5A5_3008);

        // stall holds PC and IF/ID, redirect ignored while stalled
        tick();
        chk("pre_stall_pc", im_addr, 32'h3010);
        stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_7000;
        repeat (2) tick();
        chk("stall_pc", im_addr, 32'h3010);
        chk("stall_pcd", pc_d, 32'h300C);
        chk("stall_ir", ir_d, 32'hA5A5_300C);
        stall = 1'b0; redirect_valid = 1'b0;
        tick();
        chk("unstall_pc", im_addr, 32'h3014);
        chk("unstall_pcd", pc_d, 32'h3010);

        // branch redirect; delay slot enters IF/ID with bd_d set
        redirect_valid = 1'b1; redirect_pc = 32'h3100; is_branch_d = 1'b1;
        tick();
        chk("redir_pc", im_addr, 32'h3100);
        chk("redir_pcd", pc_d, 32'h3014);
        chk("redir_bd", {31'd0, bd_d}, 32'd1);
        chk("redir_valid", {31'd0, valid_d}, 32'd1);
        redirect_valid = 1'b0; is_branch_d = 1'b0;
        tick();
        chk("tgt_pc", im_addr, 32'h3104);
        chk("tgt_pcd", pc_d, 32'h3100);
        chk("tgt_bd", {31'd0, bd_d}, 32'd0);

        // exception beats eret and stall
        exc_req = 1'b1; eret = 1'b1; stall = 1'b1; epc = 32'h5000;
        tick();
        chk("exc_pc", im_addr, 32'h4180);
        chk("exc_valid", {31'd0, valid_d}, 32'd0);
        chk("exc_ir", ir_d, 32'd0);
        chk("exc_pcd", pc_d, 32'h4180);
        exc_req = 1'b0; eret = 1'b0; stall = 1'b0;
        tick();
        chk("hdl_pcd", pc_d, 32'h4180);
        chk("hdl_ir", ir_d, 32'hA5A5_4180);

        // eret to misaligned epc, overriding stall
        eret = 1'b1; stall = 1'b1; epc = 32'h3002;
        tick();
        chk("eret_pc", im_addr, 32'h3002);
        chk("eret_pcd", pc_d, 32'h3002);
        chk("eret_valid", {31'd0, valid_d}, 32'd0);
        eret = 1'b0; stall = 1'b0;
        tick();
        chk("adel_ex", {27'd0, ex_d}, 32'd4);
        chk("adel_ir", ir_d, 32'd0);
        chk("adel_pcd", pc_d, 32'h3002);
        chk("adel_pc", im_addr, 32'h3006);

        // PC wraps modulo 2^32
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        tick();
        chk("wrap_pc", im_addr, 32'h0);
        chk("wrap_pcd", pc_d, 32'hFFFF_FFFC);

`ifdef IF_PERF_CNT_EN
        #1 reset_n = 1'b0;
        #1;
        chk("cnt_rst_f", fetch_cnt, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (10) tick();
        stall = 1'b1;
        repeat (3) tick();
        stall = 1'b0; exc_req = 1'b1;
        tick();
        exc_req = 1'b0;
        chk("fetch_cnt", fetch_cnt, 32'd10);
        chk("stall_cnt", stall_cnt, 32'd3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
